// File: rtl/line_mem_adapter.sv
// Cache-line to RAM word adapter: splits one line fill or writeback into
// LINE_WORDS single-word RAM transactions, with at most one outstanding.
module line_mem_adapter #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             RESET,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_rw,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [LINE_WORDS*WORD_WIDTH-1:0] req_data,
    output logic                             resp_valid,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] resp_data,
    output logic [ADDR_WIDTH-1:0]            ram_read_addr,
    output logic                             ram_read_addr_valid,
    input  logic                             ram_read_addr_ready,
    input  logic [WORD_WIDTH-1:0]            ram_read_data,
    input  logic                             ram_read_data_valid,
    output logic [ADDR_WIDTH-1:0]            ram_write_addr,
    output logic [WORD_WIDTH-1:0]            ram_write_data,
    output logic                             ram_write_addr_valid,
    input  logic                             ram_write_addr_ready,
    input  logic                             ram_write_resp_valid,
    output logic [WORD_WIDTH/8-1:0]          ram_strobe,
    output logic [1:0]                       ram_size,
    output logic [2:0]                       dbg_state
);

    localparam int LW       = LINE_WORDS * WORD_WIDTH;
    localparam int WB_BITS  = $clog2(WORD_WIDTH / 8);
    localparam int CNT_W    = $clog2(LINE_WORDS);
    localparam int OFF_MASK = LW / 8 - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] req_base;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [LW-1:0]         line_buf;
    logic                  last;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; once raised, valid and its payload stay stable until accepted.
    assign req_base       = req_addr & ~ADDR_WIDTH'(OFF_MASK);
    assign word_addr      = base_q + (ADDR_WIDTH'(cnt) << WB_BITS);
    assign last           = (cnt == CNT_W'(LINE_WORDS - 1));
    assign ram_read_addr  = word_addr;
    assign ram_write_addr = word_addr;
    assign ram_write_data = line_buf[int'(cnt)*WORD_WIDTH +: WORD_WIDTH];
    assign ram_strobe     = '1;
    assign ram_size       = 2'b10;
    assign dbg_state      = state;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state                <= IDLE;
            cnt                  <= '0;
            base_q               <= '0;
            line_buf             <= '0;
            resp_data            <= '0;
            resp_valid           <= 1'b0;
            req_ready            <= 1'b1;
            ram_read_addr_valid  <= 1'b0;
            ram_write_addr_valid <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base_q    <= req_base;
                        line_buf  <= req_data;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        if (req_rw) begin
                            state                <= WR_ADDR;
                            ram_write_addr_valid <= 1'b1;
                        end else begin
                            state               <= RD_ADDR;
                            ram_read_addr_valid <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (ram_read_addr_ready) begin
                        ram_read_addr_valid <= 1'b0;
                        state               <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (ram_read_data_valid) begin
                        // The fill line is assembled in place in resp_data.
                        resp_data[int'(cnt)*WORD_WIDTH +: WORD_WIDTH] <= ram_read_data;
                        if (last) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                        end else begin
                            cnt                 <= cnt + 1'b1;
                            ram_read_addr_valid <= 1'b1;
                            state               <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    if (ram_write_addr_ready) begin
                        ram_write_addr_valid <= 1'b0;
                        state                <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (ram_write_resp_valid) begin
                        if (last) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                        end else begin
                            cnt                  <= cnt + 1'b1;
                            ram_write_addr_valid <= 1'b1;
                            state                <= WR_ADDR;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state                <= IDLE;
                    req_ready            <= 1'b1;
                    ram_read_addr_valid  <= 1'b0;
                    ram_write_addr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/line_mem_adapter.md
Name: line_mem_adapter

Overview:
- Memory-side stage directly downstream of the L1 data cache controller.
- Accepts one whole 128-bit cache-line request at a time: an allocate fill (read) or a dirty writeback (write).
- Serialises the line into LINE_WORDS sequential single-word transactions on the word-wide RAM bus.
- For reads, reassembles the returned words into a full line for the cache. At most one RAM transaction is outstanding at any time.

Parameters:
ADDR_WIDTH, 32, byte address width
WORD_WIDTH, 32, RAM data word width in bits
LINE_WORDS, 4, words per cache line; power of two, >=2; line width LW = LINE_WORDS*WORD_WIDTH

Ports:
clk  in  1  single clock, rising edge
RESET  in  1  asynchronous, active-high reset
req_valid  in  1  cache presents a line request
req_ready  out  1  adapter can accept a request (IDLE only)
req_rw  in  1  0 = line fill (read), 1 = line writeback (write)
req_addr  in  ADDR_WIDTH  line address; low log2(LW/8) bits ignored
req_data  in  LW  line to write back (used when req_rw=1)
resp_valid  out  1  one-cycle pulse: request complete
resp_data  out  LW  assembled fill line; valid during resp_valid, held until next accept
ram_read_addr  out  ADDR_WIDTH  word read address
ram_read_addr_valid  out  1  read address valid
ram_read_addr_ready  in  1  RAM accepts read address
ram_read_data  in  WORD_WIDTH  read word
ram_read_data_valid  in  1  read word valid
ram_write_addr  out  ADDR_WIDTH  word write address
ram_write_data  out  WORD_WIDTH  word write data
ram_write_addr_valid  out  1  write address+data valid
ram_write_addr_ready  in  1  RAM accepts write
ram_write_resp_valid  in  1  RAM write complete
ram_strobe  out  WORD_WIDTH/8  byte enables; all ones
ram_size  out  2  transfer size; constant 2'b10 (word)

Behaviour:
- Reset (async, RESET=1): state IDLE, word counter 0, resp_data 0, resp_valid 0, all ram_*_valid 0, ram addresses and write data 0, req_ready 1. Asserting RESET mid-transaction abandons it immediately; no response is issued.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE.
- IDLE: req_ready=1. On req_valid:
  - latch line base (req_addr with offset bits cleared), rw and req_data;
  - clear counter cnt;
  - go to RD_ADDR if rw=0, WR_ADDR if rw=1.
- Word address is always base + cnt*(WORD_WIDTH/8).
- RD_ADDR: ram_read_addr_valid=1. On ram_read_addr_ready, go to RD_DATA. Valid is held, and the address stays stable, until accepted.
- RD_DATA: on ram_read_data_valid, write ram_read_data into line bits [cnt*WORD_WIDTH +: WORD_WIDTH].
  - If cnt==LINE_WORDS-1, go to DONE.
  - Otherwise increment cnt and return to RD_ADDR.
- WR_ADDR: ram_write_addr_valid=1; ram_write_data = latched line word cnt. On ram_write_addr_ready, go to WR_RESP.
- WR_RESP: on ram_write_resp_valid, go to DONE if last word, else increment cnt and return to WR_ADDR.
- DONE: resp_valid=1 for exactly one cycle; resp_data = assembled line (reads) or unchanged (writes). Next state is IDLE.
- req_ready=0 in every state except IDLE; req_valid while busy is ignored.
- ram_read_data_valid and ram_write_resp_valid are ignored outside RD_DATA and WR_RESP respectively.
- Read and write channels are never valid in the same cycle.
- Latency, zero-wait RAM (ready=1, data/resp one cycle after the address handshake):
  - request accepted at cycle 0;
  - resp_valid at cycle 2*LINE_WORDS+1, i.e. cycle 9 at defaults.
- The counter never wraps mid-line; word LINE_WORDS-1 always exits to DONE.

Test Plan:
- Reset then fill: req_addr=0x0000_1238, rw=0; RAM returns words 0xA0,0xA1,0xA2,0xA3 with zero wait -> read addresses 0x1230, 0x1234, 0x1238, 0x123C in order; resp_valid pulse at cycle 9; resp_data=0x000000A3_000000A2_000000A1_000000A0.
- Writeback: addr=0x0000_4000, req_data=0x44444444_33333333_22222222_11111111 -> write pairs (0x4000,0x11111111) ... (0x400C,0x44444444); strobe 4'hF; one resp_valid after the fourth write response.
- Backpressure: ram_read_addr_ready low for 3 cycles on word 2 -> ram_read_addr_valid and address held stable; no skipped or duplicated word; resp_valid at cycle 12.
- Busy request: req_valid held high during a fill -> req_ready=0 and the second request is not latched; it is accepted on the cycle after DONE.
- Spurious inputs: ram_read_data_valid pulsed in IDLE or RD_ADDR -> no state or data change.
- Reset mid-operation: RESET asserted during RD_DATA of word 1 -> all valids 0 immediately; no resp_valid; next fill completes normally.
